// File: rtl/text_console_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : text_console_pkg
//  Description : Shared constants and types for the character-cell text
//                console. Holds glyph geometry, the ASCII control codes
//                the write path recognises, the write FSM state encoding
//                and a printable-character helper.
//  Ports       : (package - no ports)
//  Revision    : 1.0 - initial release
// ============================================================================
package text_console_pkg;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_LF    = 7'h0A;
  localparam logic [6:0] ASCII_CR    = 7'h0D;
  localparam logic [6:0] ASCII_BS    = 7'h08;
  localparam logic [6:0] ASCII_FF    = 7'h0C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLR_ROW = 2'd1,
    ST_CLR_ALL = 2'd2
  } wr_state_t;

  // Visible characters are the only codes that land in the screen buffer.
  function automatic logic is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage
`default_nettype wire

// File: rtl/CharRom.sv
`default_nettype none
// ============================================================================
//  Module      : CharRom
//  Description : Combinational 8x16 glyph ROM. Returns one scan line of the
//                glyph for char_code; bit 7 is the leftmost pixel. Codes
//                without a stored glyph render blank.
//  Ports       : char_code [6:0] in  - ASCII code
//                row       [3:0] in  - scan line within the glyph (0 = top)
//                char_line [7:0] out - pixel bits, MSB leftmost
//  Revision    : 1.0 - initial release
// ============================================================================
module CharRom (
  input  logic [6:0] char_code,
  input  logic [3:0] row,
  output logic [7:0] char_line
);

  // Each glyph is 16 bytes packed top line first (line 0 in bits 127:120).
  localparam logic [127:0] GLYPH_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
  localparam logic [127:0] GLYPH_B = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
  localparam logic [127:0] GLYPH_X = 128'h0000_C6C6_6C7C_3838_7C6C_C6C6_0000_0000;

  logic [127:0] glyph;

  always_comb begin
    glyph = '0;
    case (char_code)
      7'h41:   glyph = GLYPH_A;
      7'h42:   glyph = GLYPH_B;
      7'h58:   glyph = GLYPH_X;
      default: glyph = '0;
    endcase
    // Line r occupies bits [127-8r -: 8]; 127-8r == {~r, 3'b111}.
    char_line = glyph[{~row, 3'b111} -: 8];
  end

endmodule
`default_nettype wire

// File: rtl/text_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer
//  Description : Simple dual-port screen RAM, one 7-bit ASCII code per cell.
//                Independent write and synchronous read ports; a read of
//                the address being written in the same cycle returns the
//                old contents. Contents are filled with spaces by the
//                console's full-screen clear, which runs out of reset.
//  Ports       : clk       in  - clock
//                wr_en_i   in  - write strobe
//                wr_addr_i in  - write cell address
//                wr_data_i in  - write data (ASCII)
//                rd_addr_i in  - read cell address
//                rd_data_o out - read data, one cycle after rd_addr_i
//  Revision    : 1.0 - initial release
// ============================================================================
module text_buffer #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [6:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [6:0]    rd_data_o
);

  logic [6:0] mem_q [DEPTH];
  logic [6:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
//  Module      : text_console
//  Description : Character-cell text console. Accepts ASCII bytes with
//                terminal-style cursor handling into a COLS x ROWS screen
//                buffer and renders it through CharRom as a 1-bit pixel
//                stream aligned with 2-cycle delayed sync/video signals.
//  Ports       : clk          in  - system/pixel clock
//                reset        in  - synchronous, active-high
//                char_in      in  - ASCII byte from upstream
//                char_valid   in  - char_in valid
//                char_ready   out - console accepts char_in this cycle
//                pixel_x/y    in  - current pixel position
//                video_on_in  in  - active video flag
//                hsync_in     in  - horizontal sync
//                vsync_in     in  - vertical sync (active low)
//                pixel_on     out - foreground pixel
//                video_on_out out - video_on_in delayed 2 cycles
//                hsync_out    out - hsync_in delayed 2 cycles
//                vsync_out    out - vsync_in delayed 2 cycles
//                cursor_col   out - cursor column
//                cursor_row   out - cursor row
//  Revision    : 1.0 - initial release
// ============================================================================
module text_console
  import text_console_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       pixel_on,
  output logic       video_on_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 12;
  localparam int BW    = $clog2(BLINK_FRAMES + 1);

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  wr_state_t      state_q, state_d;
  logic [6:0]     col_q, col_d;
  logic [4:0]     row_q, row_d;
  logic [AW-1:0]  clr_q, clr_d;
  logic           adv_row;
  logic           buf_we;
  logic [AW-1:0]  buf_waddr;
  logic [6:0]     buf_wdata;
  logic [AW-1:0]  w_cur_addr;
  logic           w_xfer;

  assign w_cur_addr = AW'(row_q) * AW'(COLS) + AW'(col_q);
  assign w_xfer     = char_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    clr_d     = clr_q;
    adv_row   = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = w_cur_addr;
    buf_wdata = ASCII_SPACE;

    unique case (state_q)
      ST_IDLE: begin
        if (w_xfer) begin
          if (is_printable(char_in)) begin
            buf_we    = 1'b1;
            buf_wdata = char_in;
            if (col_q == 7'(COLS - 1)) begin
              col_d   = '0;
              adv_row = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (char_in)
              ASCII_LF: begin
                col_d   = '0;
                adv_row = 1'b1;
              end
              ASCII_CR: col_d = '0;
              ASCII_BS: begin
                if (col_q != '0) begin
                  col_d     = col_q - 7'd1;
                  buf_we    = 1'b1;
                  buf_waddr = w_cur_addr - AW'(1);
                end
              end
              ASCII_FF: begin
                col_d   = '0;
                row_d   = '0;
                clr_d   = '0;
                state_d = ST_CLR_ALL;
              end
              default: ;
            endcase
          end
          // No scrolling: leaving the last row wraps to row 0, which is
          // blanked so the new line starts on an empty row.
          if (adv_row) begin
            if (row_q == 5'(ROWS - 1)) begin
              row_d   = '0;
              clr_d   = '0;
              state_d = ST_CLR_ROW;
            end else begin
              row_d = row_q + 5'd1;
            end
          end
        end
      end

      ST_CLR_ROW: begin
        buf_we    = 1'b1;
        buf_waddr = clr_q;
        if (clr_q == AW'(COLS - 1)) state_d = ST_IDLE;
        else                        clr_d   = clr_q + AW'(1);
      end

      ST_CLR_ALL: begin
        buf_we    = 1'b1;
        buf_waddr = clr_q;
        if (clr_q == AW'(CELLS - 1)) state_d = ST_IDLE;
        else                         clr_d   = clr_q + AW'(1);
      end

      default: begin
        clr_d   = '0;
        state_d = ST_CLR_ALL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLR_ALL;
      col_q   <= '0;
      row_q   <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      clr_q   <= clr_d;
    end
  end

  assign char_ready = (state_q == ST_IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  // --------------------------------------------------------------------------
  // Cursor blink: counts vsync falling edges
  // --------------------------------------------------------------------------
  logic          vs_prev_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q     <= 1'b1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vs_prev_q <= vsync_in;
      if (vs_prev_q && !vsync_in) begin
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Render pipeline
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_rd_addr;
  logic          w_in_grid;
  logic          w_cur_hit;
  logic [6:0]    buf_rd_data;
  logic [7:0]    w_char_line;
  logic          w_glyph_bit;

  // Out-of-grid positions produce a meaningless address; in_grid masks them.
  assign w_rd_addr = AW'(pixel_y[9:4]) * AW'(COLS) + AW'(pixel_x[9:3]);
  assign w_in_grid = (pixel_x < 10'(COLS * CHAR_W)) && (pixel_y < 10'(ROWS * CHAR_H));
  assign w_cur_hit = (pixel_x[9:3] == col_q) && (pixel_y[9:4] == {1'b0, row_q});

  text_buffer #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_text_buffer (
    .clk       (clk),
    .wr_en_i   (buf_we),
    .wr_addr_i (buf_waddr),
    .wr_data_i (buf_wdata),
    .rd_addr_i (w_rd_addr),
    .rd_data_o (buf_rd_data)
  );

  // Stage A: side-band registered in step with the buffer's read latency.
  logic [2:0] xoff_a_q;
  logic [3:0] yoff_a_q;
  logic       grid_a_q, hit_a_q, vid_a_q, hs_a_q, vs_a_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      xoff_a_q <= '0;
      yoff_a_q <= '0;
      grid_a_q <= 1'b0;
      hit_a_q  <= 1'b0;
      vid_a_q  <= 1'b0;
      hs_a_q   <= 1'b1;
      vs_a_q   <= 1'b1;
    end else begin
      xoff_a_q <= pixel_x[2:0];
      yoff_a_q <= pixel_y[3:0];
      grid_a_q <= w_in_grid;
      hit_a_q  <= w_cur_hit;
      vid_a_q  <= video_on_in;
      hs_a_q   <= hsync_in;
      vs_a_q   <= vsync_in;
    end
  end

  CharRom u_char_rom (
    .char_code (buf_rd_data),
    .row       (yoff_a_q),
    .char_line (w_char_line)
  );

  assign w_glyph_bit = w_char_line[3'd7 - xoff_a_q];

  // Stage B: final pixel, cursor cell inverted during the on phase.
  logic pixel_on_q, vid_b_q, hs_b_q, vs_b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_on_q <= 1'b0;
      vid_b_q    <= 1'b0;
      hs_b_q     <= 1'b1;
      vs_b_q     <= 1'b1;
    end else begin
      pixel_on_q <= vid_a_q & grid_a_q & (w_glyph_bit ^ (hit_a_q & blink_phase_q));
      vid_b_q    <= vid_a_q;
      hs_b_q     <= hs_a_q;
      vs_b_q     <= vs_a_q;
    end
  end

  assign pixel_on     = pixel_on_q;
  assign video_on_out = vid_b_q;
  assign hsync_out    = hs_b_q;
  assign vsync_out    = vs_b_q;

endmodule
`default_nettype wire
